// File: rtl/hazard_stall_unit.sv
// Stall/flush/freeze controller for the 5-stage MIPS pipeline: load-use and
// branch-in-ID interlocks, multi-cycle data-memory freeze with a timeout watchdog.
module hazard_stall_unit #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  IF_ID_RegisterRs,
  input  logic [4:0]  IF_ID_RegisterRt,
  input  logic        IF_ID_UsesRt,
  input  logic        IF_ID_Branch,
  input  logic        Branch_Taken,
  input  logic        ID_EX_MemRead,
  input  logic        ID_EX_RegWrite,
  input  logic [4:0]  ID_EX_RegisterRd,
  input  logic        EX_MEM_MemRead,
  input  logic        EX_MEM_MemWrite,
  input  logic [4:0]  EX_MEM_RegisterRd,
  input  logic        Mem_Ready,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        ID_EX_Bubble,
  output logic        IF_ID_Flush,
  output logic        Pipe_Freeze,
  output logic        Mem_Timeout,
  output logic [15:0] Stall_Cycles
);

  localparam logic [7:0] TMO = MEM_TIMEOUT[7:0];

  typedef enum logic {RUN, WAIT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic mem_acc, freeze, lu, bs, ex_rs, ex_rt, mem_rs, mem_rt;

  assign mem_acc = EX_MEM_MemRead | EX_MEM_MemWrite;
  // In RUN wait_cnt is 0, so this also covers the first cycle of an access.
  assign freeze  = mem_acc & ~Mem_Ready & (wait_cnt_q != TMO);

  assign ex_rs  = (ID_EX_RegisterRd != 5'd0) & (ID_EX_RegisterRd == IF_ID_RegisterRs);
  assign ex_rt  = (ID_EX_RegisterRd != 5'd0) & (ID_EX_RegisterRd == IF_ID_RegisterRt);
  assign mem_rs = (EX_MEM_RegisterRd != 5'd0) & (EX_MEM_RegisterRd == IF_ID_RegisterRs);
  assign mem_rt = (EX_MEM_RegisterRd != 5'd0) & (EX_MEM_RegisterRd == IF_ID_RegisterRt);

  assign lu = ID_EX_MemRead & (ex_rs | (IF_ID_UsesRt & ex_rt));
  // Branches compare in ID, so both operands must be final; beq/bne always read rt.
  assign bs = IF_ID_Branch & ((ID_EX_RegWrite & (ex_rs | ex_rt)) |
                              (EX_MEM_MemRead & (mem_rs | mem_rt)));

  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Bubble = 1'b0;
    IF_ID_Flush  = 1'b0;
    Pipe_Freeze  = 1'b0;
    if (reset) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
      IF_ID_Flush  = 1'b1;
    end else if (freeze) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      Pipe_Freeze = 1'b1;
    end else if (lu | bs) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end else if (IF_ID_Branch & Branch_Taken) begin
      IF_ID_Flush = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      RUN: begin
        wait_cnt_d = 8'd0;
        if (freeze) begin
          state_d    = WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      WAIT: begin
        if (freeze) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
          // Leaving with the access still pending means the watchdog expired.
          if (mem_acc & ~Mem_Ready) timeout_d = 1'b1;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
    if (!PCWrite && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= 8'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Mem_Timeout  = timeout_q;
  assign Stall_Cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: vector table, directed corner
// sequences and randomized stimulus against a rule-level reference model.
module tb_hazard_stall_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  IF_ID_RegisterRs, IF_ID_RegisterRt, ID_EX_RegisterRd, EX_MEM_RegisterRd;
  logic        IF_ID_UsesRt, IF_ID_Branch, Branch_Taken, ID_EX_MemRead, ID_EX_RegWrite;
  logic        EX_MEM_MemRead, EX_MEM_MemWrite, Mem_Ready;
  logic        PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Pipe_Freeze, Mem_Timeout;
  logic [15:0] Stall_Cycles;

  hazard_stall_unit #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .IF_ID_RegisterRs(IF_ID_RegisterRs), .IF_ID_RegisterRt(IF_ID_RegisterRt),
    .IF_ID_UsesRt(IF_ID_UsesRt), .IF_ID_Branch(IF_ID_Branch), .Branch_Taken(Branch_Taken),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite),
    .ID_EX_RegisterRd(ID_EX_RegisterRd), .EX_MEM_MemRead(EX_MEM_MemRead),
    .EX_MEM_MemWrite(EX_MEM_MemWrite), .EX_MEM_RegisterRd(EX_MEM_RegisterRd),
    .Mem_Ready(Mem_Ready), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .ID_EX_Bubble(ID_EX_Bubble), .IF_ID_Flush(IF_ID_Flush), .Pipe_Freeze(Pipe_Freeze),
    .Mem_Timeout(Mem_Timeout), .Stall_Cycles(Stall_Cycles)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state: frozen cycles spent on the current access, sticky flag, stall count
  int waited = 0;
  bit m_tmo  = 1'b0;
  int m_sc   = 0;

  typedef struct {
    logic [4:0] rs, rt;
    logic       ut, br, tk, imr, irw;
    logic [4:0] ird;
    logic       emr, emw;
    logic [4:0] erd;
    logic       rdy;
    logic [4:0] exp;  // {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Pipe_Freeze}
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic clear_in();
    {IF_ID_RegisterRs, IF_ID_RegisterRt, ID_EX_RegisterRd, EX_MEM_RegisterRd} = '0;
    {IF_ID_UsesRt, IF_ID_Branch, Branch_Taken, ID_EX_MemRead, ID_EX_RegWrite} = '0;
    {EX_MEM_MemRead, EX_MEM_MemWrite} = '0;
    Mem_Ready = 1'b0;
  endtask

  // Mid-cycle: compare all outputs against the model, then advance the model
  // to account for the coming clock edge.
  task automatic sample(input string nm);
    bit acc, fz, ld, brs, hz, pend;
    bit [4:0] e;
    @(negedge clk);
    acc  = EX_MEM_MemRead | EX_MEM_MemWrite;
    pend = acc && !Mem_Ready;
    fz   = pend && waited < TMO;
    ld   = ID_EX_MemRead && ID_EX_RegisterRd != 0 &&
           (ID_EX_RegisterRd == IF_ID_RegisterRs ||
            (IF_ID_UsesRt && ID_EX_RegisterRd == IF_ID_RegisterRt));
    brs  = IF_ID_Branch &&
           ((ID_EX_RegWrite && ID_EX_RegisterRd != 0 &&
             (ID_EX_RegisterRd == IF_ID_RegisterRs || ID_EX_RegisterRd == IF_ID_RegisterRt)) ||
            (EX_MEM_MemRead && EX_MEM_RegisterRd != 0 &&
             (EX_MEM_RegisterRd == IF_ID_RegisterRs || EX_MEM_RegisterRd == IF_ID_RegisterRt)));
    hz   = ld || brs;
    if (reset)    e = 5'b00110;
    else if (fz)  e = 5'b00001;
    else if (hz)  e = 5'b00100;
    else if (IF_ID_Branch && Branch_Taken) e = 5'b11010;
    else          e = 5'b11000;
    chk({nm, ".PCWrite"},      16'(PCWrite),      16'(e[4]));
    chk({nm, ".IF_ID_Write"},  16'(IF_ID_Write),  16'(e[3]));
    chk({nm, ".ID_EX_Bubble"}, 16'(ID_EX_Bubble), 16'(e[2]));
    chk({nm, ".IF_ID_Flush"},  16'(IF_ID_Flush),  16'(e[1]));
    chk({nm, ".Pipe_Freeze"},  16'(Pipe_Freeze),  16'(e[0]));
    chk({nm, ".Mem_Timeout"},  16'(Mem_Timeout),  16'(m_tmo));
    chk({nm, ".Stall_Cycles"}, Stall_Cycles,      16'(m_sc));
    if (reset) begin
      waited = 0; m_tmo = 1'b0; m_sc = 0;
    end else begin
      if (pend && waited == TMO) m_tmo = 1'b1;
      waited = fz ? waited + 1 : 0;
      if (!e[4] && m_sc < 65535) m_sc++;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // {rs,rt,ut,br,tk,imr,irw,ird,emr,emw,erd,rdy,exp}
    vt[0]  = '{5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 5'b11000};
    vt[1]  = '{5'd5, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0, 5'b00100};
    vt[2]  = '{5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 5'd0, 1'b0, 5'b00100};
    vt[3]  = '{5'd1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 5'd0, 1'b0, 5'b11000};
    vt[4]  = '{5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'b11000};
    vt[5]  = '{5'd1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 5'b00100};
    vt[6]  = '{5'd7, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 5'b00100};
    vt[7]  = '{5'd0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 5'b11000};
    vt[8]  = '{5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 5'b11010};
    vt[9]  = '{5'd4, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 5'd0, 1'b0, 5'b00100};
    vt[10] = '{5'd4, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 5'd0, 1'b0, 5'b11000};
    vt[11] = '{5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd2, 1'b1, 5'b11000};
    vt[12] = '{5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'b11000};

    clear_in();
    reset = 1'b1;
    adv();
    sample("reset");
    adv();
    reset = 1'b0;

    // load-use: lw $8 in EX, add using $8 in ID
    sample("idle");
    chk("idle.stall_cnt", Stall_Cycles, 16'd0);
    adv();
    ID_EX_MemRead = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_RegisterRd = 5'd8; IF_ID_RegisterRs = 5'd8;
    sample("lu");
    chk("lu.pcw", 16'(PCWrite), 16'd0);
    chk("lu.bubble", 16'(ID_EX_Bubble), 16'd1);
    adv();
    clear_in();
    IF_ID_RegisterRs = 5'd8; EX_MEM_MemRead = 1'b1; EX_MEM_RegisterRd = 5'd8; Mem_Ready = 1'b1;
    sample("lu_after");
    chk("lu_after.pcw", 16'(PCWrite), 16'd1);
    chk("lu_after.stall_cnt", Stall_Cycles, 16'd1);
    adv();

    // load $9 feeding a taken beq on $9: two stalls then one flush
    clear_in();
    ID_EX_MemRead = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_RegisterRd = 5'd9;
    IF_ID_Branch = 1'b1; IF_ID_RegisterRs = 5'd9; IF_ID_RegisterRt = 5'd3; IF_ID_UsesRt = 1'b1;
    sample("br1");
    chk("br1.pcw", 16'(PCWrite), 16'd0);
    adv();
    ID_EX_MemRead = 1'b0; ID_EX_RegWrite = 1'b0; ID_EX_RegisterRd = 5'd0;
    EX_MEM_MemRead = 1'b1; EX_MEM_RegisterRd = 5'd9; Mem_Ready = 1'b1;
    sample("br2");
    chk("br2.pcw", 16'(PCWrite), 16'd0);
    chk("br2.bubble", 16'(ID_EX_Bubble), 16'd1);
    adv();
    EX_MEM_MemRead = 1'b0; EX_MEM_RegisterRd = 5'd0; Branch_Taken = 1'b1;
    sample("br3");
    chk("br3.flush", 16'(IF_ID_Flush), 16'd1);
    chk("br3.pcw", 16'(PCWrite), 16'd1);
    adv();
    clear_in();
    sample("br4");
    chk("br4.flush", 16'(IF_ID_Flush), 16'd0);
    adv();

    for (int i = 0; i < 13; i++) begin
      IF_ID_RegisterRs = vt[i].rs; IF_ID_RegisterRt = vt[i].rt; IF_ID_UsesRt = vt[i].ut;
      IF_ID_Branch = vt[i].br; Branch_Taken = vt[i].tk; ID_EX_MemRead = vt[i].imr;
      ID_EX_RegWrite = vt[i].irw; ID_EX_RegisterRd = vt[i].ird; EX_MEM_MemRead = vt[i].emr;
      EX_MEM_MemWrite = vt[i].emw; EX_MEM_RegisterRd = vt[i].erd; Mem_Ready = vt[i].rdy;
      sample($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.table", i), 16'({PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush,
          Pipe_Freeze}), 16'(vt[i].exp));
      adv();
    end

    // memory wait of 3 cycles
    clear_in();
    EX_MEM_MemRead = 1'b1; EX_MEM_RegisterRd = 5'd10;
    for (int i = 0; i < 3; i++) begin
      sample($sformatf("mw%0d", i));
      chk($sformatf("mw%0d.freeze", i), 16'(Pipe_Freeze), 16'd1);
      adv();
    end
    Mem_Ready = 1'b1;
    sample("mw_done");
    chk("mw_done.freeze", 16'(Pipe_Freeze), 16'd0);
    adv();
    clear_in();
    sample("mw_after");
    chk("mw_after.tmo", 16'(Mem_Timeout), 16'd0);
    adv();

    // freeze beats load-use and taken branch; the stall follows on release
    EX_MEM_MemWrite = 1'b1; ID_EX_MemRead = 1'b1; ID_EX_RegisterRd = 5'd11;
    IF_ID_RegisterRs = 5'd11; IF_ID_Branch = 1'b1; Branch_Taken = 1'b1;
    sample("prio_fz");
    chk("prio_fz.ctl", 16'({PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Pipe_Freeze}),
        16'b00001);
    adv();
    Mem_Ready = 1'b1;
    sample("prio_rel");
    chk("prio_rel.ctl", 16'({PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Pipe_Freeze}),
        16'b00100);
    adv();

    // reset in the middle of a wait, then a full timeout from a clean start
    clear_in();
    EX_MEM_MemRead = 1'b1;
    sample("rw0");
    adv();
    sample("rw1");
    adv();
    reset = 1'b1;
    sample("rw_rst");
    chk("rw_rst.ctl", 16'({PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Pipe_Freeze}),
        16'b00110);
    adv();
    reset = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      sample($sformatf("to%0d", i));
      chk($sformatf("to%0d.freeze", i), 16'(Pipe_Freeze), 16'd1);
      if (i == 0) chk("to0.stall_cnt", Stall_Cycles, 16'd0);
      adv();
    end
    sample("to_exit");
    chk("to_exit.freeze", 16'(Pipe_Freeze), 16'd0);
    chk("to_exit.tmo", 16'(Mem_Timeout), 16'd0);
    adv();
    clear_in();
    sample("to_flag");
    chk("to_flag.tmo", 16'(Mem_Timeout), 16'd1);
    adv();
    sample("to_sticky");
    chk("to_sticky.tmo", 16'(Mem_Timeout), 16'd1);
    adv();

    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      IF_ID_RegisterRs = 5'($urandom_range(0, 3)); IF_ID_RegisterRt = 5'($urandom_range(0, 3));
      ID_EX_RegisterRd = 5'($urandom_range(0, 3)); EX_MEM_RegisterRd = 5'($urandom_range(0, 3));
      IF_ID_UsesRt = 1'($urandom); IF_ID_Branch = 1'($urandom); Branch_Taken = 1'($urandom);
      ID_EX_MemRead = 1'($urandom); ID_EX_RegWrite = 1'($urandom);
      EX_MEM_MemRead = ($urandom_range(0, 2) == 0); EX_MEM_MemWrite = ($urandom_range(0, 3) == 0);
      Mem_Ready = ($urandom_range(0, 2) == 0);
      sample("rand");
      adv();
    end
    reset = 1'b0;

    // hold a load-use stall long enough to saturate the counter
    clear_in();
    ID_EX_MemRead = 1'b1; ID_EX_RegisterRd = 5'd12; IF_ID_RegisterRs = 5'd12;
    repeat (70000) @(posedge clk);
    #1;
    m_sc = (m_sc + 70000 > 65535) ? 65535 : m_sc + 70000;
    sample("sat");
    chk("sat.stall_cnt", Stall_Cycles, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Stall, flush and freeze controller for the 5-stage MIPS pipeline: the stall-side companion of the forwarding path. It detects hazards that forwarding cannot cover: load-use, branch-in-ID operand dependencies and multi-cycle data-memory accesses. From these it drives the PC / IF/ID write enables, the ID/EX control bubble, the IF/ID flush and a full-pipeline freeze. It also keeps a memory-wait timeout watchdog and a saturating stall-cycle counter.

## Interface
- MEM_TIMEOUT, 15: maximum frozen cycles allowed for one memory access; range 1..255.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- IF_ID_RegisterRs / IF_ID_RegisterRt  in  5 each  source registers of the instruction in ID
- IF_ID_UsesRt  in  1  the ID instruction reads rt as a source
- IF_ID_Branch  in  1  the ID instruction is beq/bne (compared in ID)
- Branch_Taken  in  1  branch resolved taken in ID (valid only when no stall)
- ID_EX_MemRead, ID_EX_RegWrite  in  1 each
- ID_EX_RegisterRd  in  5  destination after the RegDst mux (rt for loads)
- EX_MEM_MemRead, EX_MEM_MemWrite  in  1 each
- EX_MEM_RegisterRd  in  5
- Mem_Ready  in  1  data memory completes the access this cycle
- PCWrite, IF_ID_Write  out  1 each  stage write enables
- ID_EX_Bubble  out  1  zero the control fields loaded into ID/EX
- IF_ID_Flush  out  1  replace IF/ID with a nop
- Pipe_Freeze  out  1  hold ID/EX, EX/MEM and MEM/WB; inject no bubble into MEM/WB
- Mem_Timeout  out  1  sticky watchdog flag
- Stall_Cycles  out  16  saturating count of cycles with PCWrite=0

## Operation
- FSM states: RUN, WAIT. The state register, wait_cnt (8 bit), Mem_Timeout and Stall_Cycles are the only storage.
- The outputs are combinational from the current inputs plus the state.
- mem_acc = EX_MEM_MemRead | EX_MEM_MemWrite.
- Freeze condition: freeze = mem_acc & ~Mem_Ready & (wait_cnt != MEM_TIMEOUT).
- Load-use stall (lu):
  - ID_EX_MemRead & ID_EX_RegisterRd!=0 & (ID_EX_RegisterRd==IF_ID_RegisterRs | (IF_ID_UsesRt & ID_EX_RegisterRd==IF_ID_RegisterRt)).
- Branch stall (bs): IF_ID_Branch, and a source register (rs or rt) matches a nonzero destination in either of these cases:
  - ID_EX_RegWrite & ID_EX_RegisterRd;
  - EX_MEM_MemRead & EX_MEM_RegisterRd.
- Priority: freeze > (lu | bs) > flush.
  - freeze: PCWrite=0, IF_ID_Write=0, Pipe_Freeze=1, ID_EX_Bubble=0, IF_ID_Flush=0.
  - lu | bs: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1.
  - Otherwise, if IF_ID_Branch & Branch_Taken: IF_ID_Flush=1 and PCWrite=1.
  - Otherwise all write enables are 1 and all other controls are 0.
- Transitions:
  - RUN→WAIT when freeze=1; wait_cnt becomes 1.
  - In WAIT, wait_cnt increments each cycle while freeze=1.
  - WAIT→RUN when Mem_Ready=1 or wait_cnt==MEM_TIMEOUT; wait_cnt clears to 0.
  - On the timeout exit, Mem_Timeout is set and the access is released unfinished.
- Mem_Timeout clears only on reset.
- Stall_Cycles increments on every non-reset cycle with PCWrite=0 and holds at 16'hFFFF.

## Timing
- Reset cycle and values:
  - While reset=1: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=1, Pipe_Freeze=0.
  - On the reset edge: state←RUN, wait_cnt←0, Mem_Timeout←0, Stall_Cycles←0.
- Reset asserted in WAIT abandons the wait. The first cycle after reset is evaluated in RUN.
- Stall latency:
  - Load-use and branch stalls take effect in the detection cycle, with zero latency.
  - The hazard clears naturally as the producer advances. A load feeding a branch gives 2 stall cycles; an ALU result feeding a branch gives 1.
- Freeze length: a memory access with Mem_Ready low for N cycles freezes for min(N, MEM_TIMEOUT) cycles. Mem_Ready=1 in the first cycle gives no freeze.
- Simultaneous freeze and lu/bs: freeze wins. The stall is re-evaluated after release with the inputs unchanged, so it is not lost.
- Simultaneous freeze and taken branch: the flush is deferred until the freeze ends.
- Timeout cycle: Pipe_Freeze=0 in the cycle where wait_cnt==MEM_TIMEOUT. Mem_Timeout is visible from the next cycle.
- Back-to-back memory accesses: each entry into WAIT starts from wait_cnt=0.

## Test plan
- Load-use: lw $8 in EX (ID_EX_MemRead=1, ID_EX_RegisterRd=8), add using $8 as rs in ID → exactly 1 cycle with PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1; Stall_Cycles goes from 0 to 1.
- Branch dependencies: load to $9 feeding a beq on $9 → 2 stall cycles, then IF_ID_Flush=1 for 1 cycle when Branch_Taken=1. Destination $0 in any stage → no stall.
- Memory wait: EX_MEM_MemRead=1 with Mem_Ready low for 3 cycles → Pipe_Freeze=1 for 3 cycles, state WAIT→RUN, Mem_Timeout stays 0.
- Timeout: MEM_TIMEOUT=4 and Mem_Ready held 0 → Pipe_Freeze=1 for 4 cycles, then 0. Mem_Timeout=1 from the following cycle, remaining set until reset.
- Priority and reset:
  - Load-use plus a taken branch during a freeze → only Pipe_Freeze=1; the stall follows after release.
  - Reset asserted mid-WAIT → next cycle state RUN, all counters 0.
  - 70000 stall cycles → Stall_Cycles=16'hFFFF.
